// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin2bcd converter among N_REQ requesters.
// Optional conversion timeout is enabled with `define BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
    parameter int N_REQ       = 4,
    parameter int BIN_W       = 8,
    parameter int BCD_W       = 12,
    parameter int FLUSH_CYC   = 40,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] bin_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [BCD_W-1:0]       bcd_out,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   conv_en,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic [BCD_W-1:0]       conv_bcd,
    input  logic                   conv_rdy
);
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX  = (FLUSH_CYC > TIMEOUT_CYC) ? FLUSH_CYC : TIMEOUT_CYC;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {FLUSH, IDLE, LAUNCH, WAIT, DELIVER} state_t;

    state_t          state;
    // One counter serves both the post-reset flush and the WAIT timeout.
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
`ifdef BCD_ARB_TIMEOUT_EN
    logic            to_flush;
`endif

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int k;
        pick_vld = 1'b0;
        pick_idx = '0;
        k        = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (req[k]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FLUSH;
            cnt      <= '0;
            rr_ptr   <= '0;
            idx      <= '0;
            gnt      <= '0;
            done     <= '0;
            bcd_out  <= '0;
            busy     <= 1'b1;
            conv_en  <= 1'b0;
            conv_bin <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
            to_flush    <= 1'b0;
`endif
        end else begin
            done    <= '0;
            conv_en <= 1'b0;
            case (state)
                FLUSH: begin
                    if (cnt == CW'(FLUSH_CYC - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (pick_vld) begin
                        idx      <= pick_idx;
                        conv_bin <= bin_in[pick_idx*BIN_W +: BIN_W];
                        gnt      <= N_REQ'(1) << pick_idx;
                        conv_en  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (conv_rdy) begin
                        bcd_out <= conv_bcd;
                        done    <= gnt;
                        state   <= DELIVER;
                    end
`ifdef BCD_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        bcd_out     <= '1;
                        done        <= gnt;
                        to_flush    <= 1'b1;
                        state       <= DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DELIVER: begin
                    gnt    <= '0;
                    rr_ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
`ifdef BCD_ARB_TIMEOUT_EN
                    // A converter that timed out may still be mid-conversion.
                    if (to_flush) begin
                        to_flush <= 1'b0;
                        cnt      <= '0;
                        state    <= FLUSH;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
                default: state <= FLUSH;
            endcase
        end
    end

`ifndef BCD_ARB_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter with a behavioural bin2bcd converter model.
module tb_bcd_conv_arbiter;
    localparam int N = 4, BW = 8, CW = 12, FL = 40, TO = 63, LAT = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*BW-1:0] bin_in = '0;
    logic [N-1:0]    gnt, done;
    logic [CW-1:0]   bcd_out;
    logic            busy, err_timeout, conv_en;
    logic [BW-1:0]   conv_bin;
    logic [CW-1:0]   conv_bcd = '0;
    logic            conv_rdy = 1'b0;

    bcd_conv_arbiter #(.N_REQ(N), .BIN_W(BW), .BCD_W(CW), .FLUSH_CYC(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt), .done(done),
        .bcd_out(bcd_out), .busy(busy), .err_timeout(err_timeout), .conv_en(conv_en),
        .conv_bin(conv_bin), .conv_bcd(conv_bcd), .conv_rdy(conv_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int x;
        x = int'(v);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Converter model: no reset, fixed latency, rdy suppressed when stubbed.
    logic [7:0] m_op = '0;
    int         m_cnt = 0;
    logic       stub = 1'b0;
    int         en_cnt = 0;
    always @(posedge clk) begin
        conv_rdy <= 1'b0;
        if (conv_en) begin
            m_op  <= conv_bin;
            m_cnt <= LAT;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !stub) begin
                conv_rdy <= 1'b1;
                conv_bcd <= to_bcd(m_op);
            end
        end
        if (conv_en) en_cnt <= en_cnt + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [3:0] d, output logic [11:0] b, output logic [3:0] g);
        int n;
        n = 0;
        tick();
        while (done == '0 && n < 300) begin
            tick();
            n++;
        end
        if (done == '0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: got no done within %0d cycles", n);
        end
        d = done;
        b = bcd_out;
        g = gnt;
    endtask

    task automatic wait_gnt(output int n, output logic saw_done);
        n = 0;
        saw_done = 1'b0;
        do begin
            tick();
            n++;
            if (done != '0) saw_done = 1'b1;
        end while (gnt == '0 && n < 300);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bcd"}, bcd_out, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_en"}, conv_en, 0);
        chk({tag, "_bin"}, conv_bin, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  bin;
        logic [3:0]  exp_done;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [3:0]  d, g;
        logic [11:0] b;
        logic        sd;
        int          n, en0;
        logic [3:0]  exp_ord[4];

        vt[0] = '{4'b0010, 8'd0,   4'b0010, 12'h000};
        vt[1] = '{4'b0100, 8'd99,  4'b0100, 12'h099};
        vt[2] = '{4'b1000, 8'd100, 4'b1000, 12'h100};
        vt[3] = '{4'b0001, 8'd7,   4'b0001, 12'h007};
        vt[4] = '{4'b0010, 8'd58,  4'b0010, 12'h058};
        vt[5] = '{4'b1000, 8'd200, 4'b1000, 12'h200};

        // Reset state and flush length
        tick(); tick();
        chk_reset_vals("rst0");
        rst = 1'b0;
        req = 4'b0001;
        bin_in[0 +: BW] = 8'd255;
        wait_gnt(n, sd);
        chk("flush_len", n, FL + 1);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_en", conv_en, 1);
        chk("t1_bin", conv_bin, 8'd255);
        en0 = en_cnt;
        wait_done(d, b, g);
        req = '0;
        chk("t1_done", d, 4'b0001);
        chk("t1_bcd", b, 12'h255);
        chk("t1_gnt_at_done", g, 4'b0001);
        chk("t1_en_pulses", en_cnt - en0, 1);
        tick(); tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_gnt", gnt, 0);

        // Single-requester vectors
        for (int i = 0; i < 6; i++) begin
            bin_in = {N{8'hA5}};
            for (int j = 0; j < N; j++)
                if (vt[i].req[j]) bin_in[j*BW +: BW] = vt[i].bin;
            req = vt[i].req;
            wait_done(d, b, g);
            req = '0;
            chk($sformatf("vec%0d_done", i), d, vt[i].exp_done);
            chk($sformatf("vec%0d_bcd", i), b, vt[i].exp_bcd);
            chk($sformatf("vec%0d_gnt", i), g, vt[i].exp_done);
            tick(); tick();
        end

        // All four requesting: rotating order from pointer 0
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bin_in = {8'd4, 8'd3, 8'd2, 8'd1};
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, b, g);
            req = req & ~d;
            chk($sformatf("all_done%0d", k), d, exp_ord[k]);
            chk($sformatf("all_bcd%0d", k), b, 12'(k + 1));
        end
        req = '0;
        tick(); tick();

        // Two requesters held high alternate
        exp_ord = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, b, g);
            if (k == 3) req = '0;
            chk($sformatf("alt_done%0d", k), d, exp_ord[k]);
            chk($sformatf("alt_bcd%0d", k), b, (exp_ord[k] == 4'b0001) ? 12'h001 : 12'h003);
        end
        tick(); tick();

        // Operand change after grant is ignored
        bin_in[1*BW +: BW] = 8'd50;
        req = 4'b0010;
        wait_gnt(n, sd);
        bin_in[1*BW +: BW] = 8'd77;
        wait_done(d, b, g);
        req = '0;
        chk("op_done", d, 4'b0010);
        chk("op_bcd", b, 12'h050);
        chk("op_bin", conv_bin, 8'd50);
        tick(); tick();

        // Reset mid-WAIT
        bin_in[0 +: BW] = 8'd123;
        req = 4'b0001;
        wait_gnt(n, sd);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst1");
        wait_gnt(n, sd);
        chk("rst1_flush_len", n, FL + 1);
        chk("rst1_no_done", sd, 0);
        chk("rst1_bcd_hold", bcd_out, 0);
        chk("rst1_gnt", gnt, 4'b0001);
        wait_done(d, b, g);
        req = '0;
        chk("rst1_done", d, 4'b0001);
        chk("rst1_bcd", b, 12'h123);
        tick(); tick();

`ifdef BCD_ARB_TIMEOUT_EN
        // Converter never answers
        stub = 1'b1;
        bin_in[2*BW +: BW] = 8'd9;
        req = 4'b0100;
        wait_gnt(n, sd);
        n = 0;
        while (done == '0 && n < 300) begin
            tick();
            n++;
        end
        req = '0;
        chk("to_latency", n, TO + 1);
        chk("to_done", done, 4'b0100);
        chk("to_bcd", bcd_out, 12'hFFF);
        chk("to_err", err_timeout, 1);
        repeat (5) tick();
        chk("to_err_sticky", err_timeout, 1);
        chk("to_flush_busy", busy, 1);
        stub = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_err_clr", err_timeout, 0);
`else
        chk("err_tied", err_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500000");
        $fatal(1);
    end
endmodule
